analog_ctrl_conditioner: RTL and testbench

//  Upstream stage of the analog student area: conditions the raw 16-bit PMOD GPI word before it

---
 rtl/student_analog_pkg.sv | 25 ++
 rtl/gpi_sync.sv | 33 +++
 rtl/analog_ctrl_conditioner.sv | 129 ++++++++++++
 tb/tb_analog_ctrl_conditioner.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/student_analog_pkg.sv
// Shared types and constants for the analog control conditioner.
// Imported by the conditioner top and its synchroniser.
package student_analog_pkg;

  typedef enum logic {
    IDLE,
    SETTLE
  } actrl_state_e;

  localparam int ACTRL_WIDTH = 16;
  localparam int ACTRL_CNT_W = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ACTRL_CNT_W-1:0] sat_inc(
    input logic [ACTRL_CNT_W-1:0] v
  );
    logic [ACTRL_CNT_W-1:0] r;
    r = v;
    if (v != {ACTRL_CNT_W{1'b1}}) begin
      r = v + ACTRL_CNT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/gpi_sync.sv
// Per-bit multi-flop synchroniser for asynchronous GPI inputs.
// Skew between bits is left for the downstream debounce to absorb.
module gpi_sync
  import student_analog_pkg::*;
#(
  parameter int WIDTH  = ACTRL_WIDTH,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  // Shift every bit through its own flop chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/analog_ctrl_conditioner.sv
// Conditions the raw PMOD GPI word before it reaches the analog block:
// synchronise, whole-word debounce, gated update, settle hold-off.
module analog_ctrl_conditioner
  import student_analog_pkg::*;
#(
  parameter int               WIDTH           = ACTRL_WIDTH,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 16,
  parameter int               SETTLE_CYCLES   = 64,
  parameter logic [WIDTH-1:0] RESET_CTRL      = '0
) (
  input  logic                   clk_in,
  input  logic                   reset_int,
  input  logic [WIDTH-1:0]       pmod_gpi,
  input  logic                   ctrl_en,
  output logic [WIDTH-1:0]       control_o,
  output logic                   ctrl_update,
  output logic                   busy,
  output logic [ACTRL_CNT_W-1:0] update_cnt
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int ST_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_MAX =
    DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_INIT =
    ST_W'(SETTLE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] cand_q;
  logic [DB_W-1:0]  db_cnt_q;
  logic             stable;

  actrl_state_e     state_q;
  actrl_state_e     state_d;
  logic [ST_W-1:0]  settle_q;
  logic [ST_W-1:0]  settle_d;
  logic [WIDTH-1:0] ctrl_q;
  logic [WIDTH-1:0] ctrl_d;
  logic             upd_q;
  logic             upd_d;
  logic             busy_q;
  logic             busy_d;
  logic [ACTRL_CNT_W-1:0] cnt_q;
  logic [ACTRL_CNT_W-1:0] cnt_d;

  gpi_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk_in),
    .rst (reset_int),
    .d   (pmod_gpi),
    .q   (sync_q)
  );

  // Whole-word debounce: any change restarts the stability count.
  always_ff @(posedge clk_in or posedge reset_int) begin
    if (reset_int) begin
      cand_q   <= '0;
      db_cnt_q <= '0;
    end else if (sync_q != cand_q) begin
      cand_q   <= sync_q;
      db_cnt_q <= '0;
    end else if (db_cnt_q != DB_MAX) begin
      db_cnt_q <= db_cnt_q + DB_W'(1);
    end
  end

  assign stable = (db_cnt_q == DB_MAX);

  // Apply/settle state and registered outputs.
  always_ff @(posedge clk_in or posedge reset_int) begin
    if (reset_int) begin
      state_q  <= IDLE;
      settle_q <= '0;
      ctrl_q   <= RESET_CTRL;
      upd_q    <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      ctrl_q   <= ctrl_d;
      upd_q    <= upd_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state: apply a stable differing word, then hold off.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    ctrl_d   = ctrl_q;
    upd_d    = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (stable && ctrl_en &&
            (cand_q != ctrl_q)) begin
          ctrl_d   = cand_q;
          upd_d    = 1'b1;
          cnt_d    = sat_inc(cnt_q);
          settle_d = ST_INIT;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q == '0) begin
          state_d = IDLE;
        end else begin
          settle_d = settle_q - ST_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SETTLE);
  end

  assign control_o   = ctrl_q;
  assign ctrl_update = upd_q;
  assign busy        = busy_q;
  assign update_cnt  = cnt_q;

endmodule

// File: tb/tb_analog_ctrl_conditioner.sv
// Self-checking bench for analog_ctrl_conditioner.
// Table vectors, directed corner cases and a random run vs a model.
module tb_analog_ctrl_conditioner;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pmod;
  logic        en;
  logic [15:0] control_o;
  logic        ctrl_update;
  logic        busy;
  logic [7:0]  update_cnt;

  analog_ctrl_conditioner dut (
    .clk_in      (clk),
    .reset_int   (rst),
    .pmod_gpi    (pmod),
    .ctrl_en     (en),
    .control_o   (control_o),
    .ctrl_update (ctrl_update),
    .busy        (busy),
    .update_cnt  (update_cnt)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Reference model: input delayed by two samples, run length of
  // equal synced samples, remaining hold-off cycles.
  logic [15:0] h1, h2, vv, m_ctrl;
  int          run, m_settle, m_cnt;
  bit          m_upd;

  typedef struct {
    logic [15:0] val;
    logic        ena;
    int          hold;
    logic [15:0] exp_ctrl;
    int          exp_cnt;
  } vec_t;

  vec_t tbl [8];

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  task automatic model_reset();
    h1 = 0; h2 = 0; vv = 0; run = 1;
    m_ctrl = 0; m_upd = 0; m_settle = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit st;
    st = (run >= 16);
    m_upd = 0;
    if (m_settle > 0) begin
      m_settle--;
    end else if (st && en && vv != m_ctrl) begin
      m_ctrl = vv;
      m_upd = 1;
      if (m_cnt < 255) m_cnt++;
      m_settle = 64;
    end
    if (h2 == vv) begin
      if (run < 16) run++;
    end else begin
      vv = h2;
      run = 1;
    end
    h2 = h1;
    h1 = pmod;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    check("m_ctrl", 32'(control_o), 32'(m_ctrl));
    check("m_upd", 32'(ctrl_update), 32'(m_upd));
    check("m_busy", 32'(busy), 32'(m_settle > 0));
    check("m_cnt", 32'(update_cnt), 32'(m_cnt));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check("idle_bound", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    bit seen;
    rst = 1'b1;
    pmod = '0;
    en = 1'b0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;

    // 1: quiet after reset
    repeat (100) tick();
    check("rst_ctrl", 32'(control_o), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_upd", 32'(ctrl_update), 32'd0);
    check("rst_cnt", 32'(update_cnt), 32'd0);

    // table vectors
    tbl[0] = '{16'hA5C3, 1'b1, 100, 16'hA5C3, 1};
    tbl[1] = '{16'h1234, 1'b0, 100, 16'hA5C3, 1};
    tbl[2] = '{16'h1234, 1'b1, 5,   16'h1234, 2};
    tbl[3] = '{16'h00FF, 1'b1, 100, 16'h00FF, 3};
    tbl[4] = '{16'h00FF, 1'b0, 50,  16'h00FF, 3};
    tbl[5] = '{16'hFFFF, 1'b1, 10,  16'h00FF, 3};
    tbl[6] = '{16'h00FF, 1'b1, 100, 16'h00FF, 3};
    tbl[7] = '{16'h0000, 1'b1, 100, 16'h0000, 4};
    for (int i = 0; i < 8; i++) begin
      pmod = tbl[i].val;
      en = tbl[i].ena;
      repeat (tbl[i].hold) tick();
      check($sformatf("tbl%0d_ctrl", i),
            32'(control_o), 32'(tbl[i].exp_ctrl));
      check($sformatf("tbl%0d_cnt", i),
            32'(update_cnt), 32'(tbl[i].exp_cnt));
    end

    do_reset();
    repeat (30) tick();

    // 3: short glitch
    en = 1'b1;
    pmod = 16'hFFFF;
    repeat (10) tick();
    pmod = 16'h0000;
    seen = 0;
    repeat (60) begin
      tick();
      if (ctrl_update) seen = 1;
    end
    check("glitch_upd", 32'(seen), 32'd0);
    check("glitch_ctrl", 32'(control_o), 32'h0);

    // 2: latency, pulse width, busy length
    pmod = 16'hA5C3;
    repeat (18) tick();
    check("lat18_ctrl", 32'(control_o), 32'h0);
    tick();
    check("lat19_ctrl", 32'(control_o), 32'hA5C3);
    check("lat19_upd", 32'(ctrl_update), 32'd1);
    check("lat19_cnt", 32'(update_cnt), 32'd1);
    n = busy ? 1 : 0;
    tick();
    check("pulse_end", 32'(ctrl_update), 32'd0);
    while (busy && n < 200) begin
      n++;
      tick();
    end
    check("busy_len", 32'(n), 32'd64);

    // 4: change during settle lands right after busy falls
    pmod = 16'h0001;
    n = 0;
    while (!ctrl_update && n < 40) begin
      tick();
      n++;
    end
    check("s4_first", 32'(control_o), 32'h0001);
    repeat (5) tick();
    pmod = 16'h0002;
    n = 0;
    while (busy && n < 100) begin
      check("s4_hold", 32'(control_o), 32'h0001);
      tick();
      n++;
    end
    check("s4_fall_ctrl", 32'(control_o), 32'h0001);
    tick();
    check("s4_next_ctrl", 32'(control_o), 32'h0002);
    check("s4_next_upd", 32'(ctrl_update), 32'd1);

    // 5: enable gating, then apply on the rising edge
    wait_idle();
    en = 1'b0;
    pmod = 16'h1234;
    seen = 0;
    repeat (40) begin
      tick();
      if (ctrl_update) seen = 1;
    end
    check("s5_noupd", 32'(seen), 32'd0);
    check("s5_hold", 32'(control_o), 32'h0002);
    en = 1'b1;
    tick();
    check("s5_ctrl", 32'(control_o), 32'h1234);
    check("s5_upd", 32'(ctrl_update), 32'd1);

    // 6: reset mid-settle, then reapply
    repeat (29) tick();
    #1;
    rst = 1'b1;
    #1;
    check("s6_busy", 32'(busy), 32'd0);
    check("s6_ctrl", 32'(control_o), 32'h0);
    check("s6_cnt", 32'(update_cnt), 32'd0);
    check("s6_upd", 32'(ctrl_update), 32'd0);
    model_reset();
    tick();
    rst = 1'b0;
    repeat (18) tick();
    check("s6_18", 32'(control_o), 32'h0);
    tick();
    check("s6_19", 32'(control_o), 32'h1234);
    check("s6_cnt1", 32'(update_cnt), 32'd1);

    // random stimulus against the model
    for (int s = 0; s < 150; s++) begin
      case ($urandom_range(0, 3))
        0: pmod = 16'h0000;
        1: pmod = 16'hFFFF;
        2: pmod = 16'($urandom);
        default: pmod = m_ctrl;
      endcase
      en = ($urandom_range(0, 4) != 0);
      repeat ($urandom_range(1, 40)) tick();
    end

    // saturation of the update counter
    en = 1'b1;
    for (int s = 0; s < 262; s++) begin
      pmod = s[0] ? 16'h5555 : 16'hAAAA;
      repeat (90) tick();
    end
    check("sat_cnt", 32'(update_cnt), 32'd255);
    check("sat_ctrl", 32'(control_o), 32'h5555);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
